// File: rtl/kinase_valve_sequencer_if.sv
// kinase_valve_sequencer_if: host command channel (valid/ready handshake, opcode, payload, stroke count, abort)
interface kinase_valve_sequencer_if #(
  parameter int STROKE_W = 8
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_op;
  logic [21:0]         cmd_data;
  logic [STROKE_W-1:0] cmd_count;
  logic                abort;

  modport master (output cmd_valid, cmd_op, cmd_data, cmd_count, abort, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_data, cmd_count, abort, output cmd_ready);
endinterface

// File: rtl/kinase_valve_sequencer.sv
// kinase_valve_sequencer: one-command-at-a-time valve/pump/vent sequencer for the kinase bank.
// Define KINASE_SEQ_INTERLOCK_EN to insert a DEADTIME gap between valve release and vent assert.
module kinase_valve_sequencer #(
  parameter int PHASE_CYCLES = 4,
  parameter int FLUSH_CYCLES = 8,
  parameter int DEADTIME     = 2,
  parameter int STROKE_W     = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  kinase_valve_sequencer_if.slave cmd,
  output logic [12:0]             ctrl_a_o,
  output logic [3:0]              ctrl_s_o,
  output logic [2:0]              pump_a_o,
  output logic [1:0]              pump_b_o,
  output logic [12:0]             flush_ctrl_a_o,
  output logic [3:0]              flush_ctrl_s_o,
  output logic [2:0]              flush_pump_a_o,
  output logic [1:0]              flush_pump_b_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    aborted_o
);
  localparam int M1   = PHASE_CYCLES > FLUSH_CYCLES ? PHASE_CYCLES : FLUSH_CYCLES;
  localparam int CMAX = M1 > DEADTIME ? M1 : DEADTIME;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [1:0] OP_SET = 2'd0, OP_PA = 2'd1, OP_PB = 2'd2, OP_FL = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_PUMPA, S_PUMPB, S_FLUSH
`ifdef KINASE_SEQ_INTERLOCK_EN
    , S_DEAD
`endif
  } state_t;

`ifdef KINASE_SEQ_INTERLOCK_EN
  localparam state_t S_FLIN = S_DEAD;
`else
  localparam state_t S_FLIN = S_FLUSH;
`endif

  state_t              state_q, state_d, go_s;
  logic [12:0]         ctrl_a_q, ctrl_a_d;
  logic [3:0]          ctrl_s_q, ctrl_s_d;
  logic [2:0]          pump_a_q, pump_a_d;
  logic [1:0]          pump_b_q, pump_b_d;
  logic [21:0]         flush_q, flush_d;
  logic [CW-1:0]       cnt_q, cnt_d, lim;
  logic [2:0]          step_q, step_d;
  logic [STROKE_W-1:0] strokes_q, strokes_d;
  logic                done_q, done_d, aborted_q, aborted_d;
  logic                accept, phase_end, last_step, last_stroke;
`ifdef KINASE_SEQ_INTERLOCK_EN
  logic [21:0]         mask_q, mask_d;
`endif

  function automatic logic [2:0] pa_pat(input logic [2:0] i);
    return i == 3'd0 ? 3'b011 : i == 3'd1 ? 3'b001 : i == 3'd2 ? 3'b101 :
           i == 3'd3 ? 3'b100 : i == 3'd4 ? 3'b110 : 3'b010;
  endfunction

  function automatic logic [1:0] pb_pat(input logic [2:0] i);
    return i == 3'd0 ? 2'b10 : 2'b01;
  endfunction

  assign cmd.cmd_ready = rst_n && state_q == S_IDLE;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign lim = state_q == S_FLUSH ? CW'(FLUSH_CYCLES - 1) :
`ifdef KINASE_SEQ_INTERLOCK_EN
               state_q == S_DEAD  ? CW'(DEADTIME - 1) :
`endif
               CW'(PHASE_CYCLES - 1);
  assign phase_end   = cnt_q == lim;
  assign last_step   = step_q == (state_q == S_PUMPA ? 3'd5 : 3'd1);
  assign last_stroke = strokes_q == STROKE_W'(1);
  assign go_s = cmd.cmd_op == OP_PA && |cmd.cmd_count ? S_PUMPA :
                cmd.cmd_op == OP_PB && |cmd.cmd_count ? S_PUMPB :
                cmd.cmd_op == OP_FL ? S_FLIN : S_IDLE;

  assign ctrl_a_o       = ctrl_a_q;
  assign ctrl_s_o       = ctrl_s_q;
  assign pump_a_o       = pump_a_q;
  assign pump_b_o       = pump_b_q;
  assign flush_ctrl_a_o = flush_q[12:0];
  assign flush_ctrl_s_o = flush_q[16:13];
  assign flush_pump_a_o = flush_q[19:17];
  assign flush_pump_b_o = flush_q[21:20];
  assign busy_o         = state_q != S_IDLE;
  assign done_o         = done_q;
  assign aborted_o      = aborted_q;

  // State and datapath registers; async reset leaves valves released and pumps idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ctrl_a_q  <= '0;
      ctrl_s_q  <= '0;
      pump_a_q  <= 3'b111;
      pump_b_q  <= 2'b11;
      flush_q   <= '0;
      cnt_q     <= '0;
      step_q    <= '0;
      strokes_q <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
`ifdef KINASE_SEQ_INTERLOCK_EN
      mask_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ctrl_a_q  <= ctrl_a_d;
      ctrl_s_q  <= ctrl_s_d;
      pump_a_q  <= pump_a_d;
      pump_b_q  <= pump_b_d;
      flush_q   <= flush_d;
      cnt_q     <= cnt_d;
      step_q    <= step_d;
      strokes_q <= strokes_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
`ifdef KINASE_SEQ_INTERLOCK_EN
      mask_q    <= mask_d;
`endif
    end
  end

  // Next state: abort beats completion; immediate commands never leave IDLE
  always_comb begin
    state_d = state_q;
    if (state_q == S_IDLE) state_d = accept ? go_s : S_IDLE;
    else if (cmd.abort) state_d = S_IDLE;
    else if (phase_end && state_q == S_FLUSH) state_d = S_IDLE;
`ifdef KINASE_SEQ_INTERLOCK_EN
    else if (phase_end && state_q == S_DEAD) state_d = S_FLUSH;
`endif
    else if (phase_end && last_step && last_stroke) state_d = S_IDLE;
  end

  // Output and counter next values: phase timer, stroke step walk, vent masking
  always_comb begin
    ctrl_a_d  = ctrl_a_q;
    ctrl_s_d  = ctrl_s_q;
    pump_a_d  = pump_a_q;
    pump_b_d  = pump_b_q;
    flush_d   = flush_q;
    cnt_d     = cnt_q;
    step_d    = step_q;
    strokes_d = strokes_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
`ifdef KINASE_SEQ_INTERLOCK_EN
    mask_d    = mask_q;
`endif
    if (state_q == S_IDLE) begin
      if (accept) begin
        cnt_d     = '0;
        step_d    = '0;
        strokes_d = cmd.cmd_count;
        done_d    = go_s == S_IDLE;
        if (cmd.cmd_op == OP_SET) begin
          ctrl_a_d = cmd.cmd_data[12:0];
          ctrl_s_d = cmd.cmd_data[16:13];
        end
        if (go_s == S_PUMPA) pump_a_d = pa_pat(3'd0);
        if (go_s == S_PUMPB) pump_b_d = pb_pat(3'd0);
        if (cmd.cmd_op == OP_FL) begin
          ctrl_a_d = ctrl_a_q & ~cmd.cmd_data[12:0];
          ctrl_s_d = ctrl_s_q & ~cmd.cmd_data[16:13];
          pump_a_d = pump_a_q & ~cmd.cmd_data[19:17];
          pump_b_d = pump_b_q & ~cmd.cmd_data[21:20];
`ifdef KINASE_SEQ_INTERLOCK_EN
          mask_d   = cmd.cmd_data;
`else
          flush_d  = cmd.cmd_data;
`endif
        end
      end
    end else if (cmd.abort) begin
      pump_a_d  = 3'b111;
      pump_b_d  = 2'b11;
      flush_d   = '0;
      aborted_d = 1'b1;
    end else begin
      cnt_d = phase_end ? '0 : cnt_q + 1'b1;
      if (phase_end && state_q == S_FLUSH) begin
        flush_d  = '0;
        pump_a_d = 3'b111;
        pump_b_d = 2'b11;
        done_d   = 1'b1;
      end
`ifdef KINASE_SEQ_INTERLOCK_EN
      else if (phase_end && state_q == S_DEAD) flush_d = mask_q;
`endif
      else if (phase_end && last_step && last_stroke) begin
        pump_a_d = 3'b111;
        pump_b_d = 2'b11;
        done_d   = 1'b1;
      end else if (phase_end && last_step) begin
        step_d    = '0;
        strokes_d = strokes_q - 1'b1;
        pump_a_d  = state_q == S_PUMPA ? pa_pat(3'd0) : pump_a_q;
        pump_b_d  = state_q == S_PUMPB ? pb_pat(3'd0) : pump_b_q;
      end else if (phase_end) begin
        step_d   = step_q + 3'd1;
        pump_a_d = state_q == S_PUMPA ? pa_pat(step_q + 3'd1) : pump_a_q;
        pump_b_d = state_q == S_PUMPB ? pb_pat(step_q + 3'd1) : pump_b_q;
      end
    end
  end
endmodule

// File: tb/tb_kinase_valve_sequencer.sv
// tb_kinase_valve_sequencer: vector table, corner-case sequences and random commands against a timeline model
module tb_kinase_valve_sequencer;
  localparam int P  = 4;
  localparam int F  = 8;
  localparam int D  = 2;
  localparam int SW = 8;
`ifdef KINASE_SEQ_INTERLOCK_EN
  localparam int DL = D;
`else
  localparam int DL = 0;
`endif
  localparam logic [1:0] OP_SET = 2'd0, OP_PA = 2'd1, OP_PB = 2'd2, OP_FL = 2'd3;
  localparam logic [2:0] SA [6] = '{3'b011, 3'b001, 3'b101, 3'b100, 3'b110, 3'b010};
  localparam logic [1:0] SB [2] = '{2'b10, 2'b01};

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  kinase_valve_sequencer_if #(.STROKE_W(SW)) cmd ();

  logic [12:0] ctrl_a, fa;
  logic [3:0]  ctrl_s, fs;
  logic [2:0]  pump_a, fpa;
  logic [1:0]  pump_b, fpb;
  logic        busy, done, aborted;

  kinase_valve_sequencer #(.PHASE_CYCLES(P), .FLUSH_CYCLES(F), .DEADTIME(D), .STROKE_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd),
    .ctrl_a_o(ctrl_a), .ctrl_s_o(ctrl_s), .pump_a_o(pump_a), .pump_b_o(pump_b),
    .flush_ctrl_a_o(fa), .flush_ctrl_s_o(fs), .flush_pump_a_o(fpa), .flush_pump_b_o(fpb),
    .busy_o(busy), .done_o(done), .aborted_o(aborted)
  );

  int n_cmp = 0, n_bad = 0;
  int nbusy, ffl, nfl, novl;
  logic [12:0] m_a;
  logic [3:0]  m_s;

  typedef struct {
    logic [1:0]  op;
    logic [21:0] dat;
    int          cnt;
    logic [12:0] ea;
    logic [3:0]  es;
  } vec_t;
  vec_t tbl [6];

  function automatic logic [47:0] mk(input logic r, input logic b, input logic d, input logic ab,
                                     input logic [12:0] ca, input logic [3:0] cs,
                                     input logic [2:0] pa, input logic [1:0] pb, input logic [21:0] fl);
    return {r, b, d, ab, ca, cs, pa, pb, fl};
  endfunction

  function automatic logic [47:0] act_out();
    return {cmd.cmd_ready, busy, done, aborted, ctrl_a, ctrl_s, pump_a, pump_b, fpb, fpa, fs, fa};
  endfunction

  function automatic int total(input logic [1:0] op, input int c);
    return op == OP_PA ? 6 * P * c : op == OP_PB ? 2 * P * c : op == OP_FL ? DL + F : 0;
  endfunction

  // Expected outputs k cycles after the first post-accept edge
  function automatic logic [47:0] expect_at(input logic [1:0] op, input logic [21:0] dat, input int c, input int k);
    logic [2:0]  pa;
    logic [1:0]  pb;
    logic [21:0] fl;
    pa = 3'b111;
    pb = 2'b11;
    fl = '0;
    if (k >= total(op, c)) return mk(1'b1, 1'b0, 1'b1, 1'b0, m_a, m_s, 3'b111, 2'b11, '0);
    if (op == OP_PA) pa = SA[(k / P) % 6];
    if (op == OP_PB) pb = SB[(k / P) % 2];
    if (op == OP_FL) begin
      pa = ~dat[19:17];
      pb = ~dat[21:20];
      if (k >= DL) fl = dat;
    end
    return mk(1'b0, 1'b1, 1'b0, 1'b0, m_a, m_s, pa, pb, fl);
  endfunction

  task automatic check(input string nm, input logic [47:0] act, input logic [47:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [47:0] idle_exp();
    return mk(1'b1, 1'b0, 1'b0, 1'b0, m_a, m_s, 3'b111, 2'b11, '0);
  endfunction

  // Issue one command and follow it to done (or to abort when ab_at is reached)
  task automatic run_cmd(input logic [1:0] op, input logic [21:0] dat, input int c, input int ab_at, input bit ab_acc);
    int t;
    t = total(op, c);
    nbusy = 0;
    ffl = -1;
    nfl = 0;
    novl = 0;
    cmd.cmd_valid = 1'b1;
    cmd.cmd_op = op;
    cmd.cmd_data = dat;
    cmd.cmd_count = SW'(c);
    cmd.abort = ab_acc;
    tick();
    cmd.cmd_valid = 1'b0;
    cmd.abort = 1'b0;
    if (op == OP_SET) begin
      m_a = dat[12:0];
      m_s = dat[16:13];
    end
    if (op == OP_FL) begin
      m_a = m_a & ~dat[12:0];
      m_s = m_s & ~dat[16:13];
    end
    for (int k = 0; k <= t; k++) begin
      check("cmd_cycle", act_out(), expect_at(op, dat, c, k));
      if (busy) nbusy++;
      if (fa[0]) begin
        nfl++;
        if (ffl < 0) ffl = k;
      end
      if (|(ctrl_a & fa) || |(ctrl_s & fs) || |(pump_a & fpa) || |(pump_b & fpb)) novl++;
      if (k == t) break;
      cmd.cmd_valid = $urandom_range(0, 3) == 0;
      cmd.cmd_op = 2'($urandom);
      cmd.cmd_data = 22'($urandom);
      cmd.cmd_count = SW'($urandom);
      cmd.abort = k == ab_at;
      tick();
      cmd.cmd_valid = 1'b0;
      if (k == ab_at) begin
        cmd.abort = 1'b0;
        check("abort_cycle", act_out(), mk(1'b1, 1'b0, 1'b0, 1'b1, m_a, m_s, 3'b111, 2'b11, '0));
        break;
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    cmd.cmd_valid = 1'b0;
    cmd.cmd_op = '0;
    cmd.cmd_data = '0;
    cmd.cmd_count = '0;
    cmd.abort = 1'b0;
    m_a = '0;
    m_s = '0;
    tbl[0] = '{OP_SET, 22'h012345, 0, 13'h0345, 4'h9};
    tbl[1] = '{OP_PB,  22'h3FFFFF, 0, 13'h0345, 4'h9};
    tbl[2] = '{OP_SET, 22'h3FFFFF, 0, 13'h1FFF, 4'hF};
    tbl[3] = '{OP_PA,  22'h000000, 0, 13'h1FFF, 4'hF};
    tbl[4] = '{OP_SET, 22'h000000, 0, 13'h0000, 4'h0};
    tbl[5] = '{OP_SET, 22'h000001, 0, 13'h0001, 4'h0};

    #1 rst_n = 1'b0;
    #1 check("reset_held", act_out(), mk(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 3'b111, 2'b11, '0));
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1 check("reset_release", act_out(), idle_exp());

    for (int i = 0; i < 6; i++) begin
      cmd.cmd_valid = 1'b1;
      cmd.cmd_op = tbl[i].op;
      cmd.cmd_data = tbl[i].dat;
      cmd.cmd_count = SW'(tbl[i].cnt);
      tick();
      cmd.cmd_valid = 1'b0;
      check("vec_done", act_out(), mk(1'b1, 1'b0, 1'b1, 1'b0, tbl[i].ea, tbl[i].es, 3'b111, 2'b11, '0));
      tick();
      check("vec_idle", act_out(), mk(1'b1, 1'b0, 1'b0, 1'b0, tbl[i].ea, tbl[i].es, 3'b111, 2'b11, '0));
      m_a = tbl[i].ea;
      m_s = tbl[i].es;
    end

    run_cmd(OP_PA, '0, 2, -1, 1'b0);
    check_int("pumpa_busy_cycles", nbusy, 48);

    run_cmd(OP_FL, 22'h000001, 0, -1, 1'b0);
    check_int("flush_start", ffl, DL);
    check_int("flush_len", nfl, F);
    check_int("flush_overlap", novl, 0);

    run_cmd(OP_SET, 22'h3FFFFF, 0, -1, 1'b0);
    run_cmd(OP_FL, 22'h3FFFFF, 0, -1, 1'b0);
    check_int("flush_all_overlap", novl, 0);

    run_cmd(OP_PA, '0, 3, 2 * P + 1, 1'b0);
    run_cmd(OP_PB, '0, 1, 2 * P - 1, 1'b0);
    run_cmd(OP_FL, 22'h3FFFFF, 0, 0, 1'b0);

    cmd.abort = 1'b1;
    tick();
    cmd.abort = 1'b0;
    check("idle_abort_ignored", act_out(), idle_exp());
    run_cmd(OP_PB, '0, 1, -1, 1'b1);

    repeat (60) begin
      logic [1:0]  op;
      logic [21:0] dat;
      int c, t, ab;
      op = 2'($urandom);
      dat = 22'($urandom);
      c = $urandom_range(0, 3);
      t = total(op, c);
      ab = (t > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, t - 1) : -1;
      run_cmd(op, dat, c, ab, $urandom_range(0, 7) == 0);
      repeat ($urandom_range(0, 2)) begin
        cmd.abort = $urandom_range(0, 1) == 1;
        tick();
        cmd.abort = 1'b0;
        check("gap_idle", act_out(), idle_exp());
      end
    end

    run_cmd(OP_SET, 22'h3FFFFF, 0, -1, 1'b0);
    cmd.cmd_valid = 1'b1;
    cmd.cmd_op = OP_FL;
    cmd.cmd_data = 22'h3FFFFF;
    tick();
    cmd.cmd_valid = 1'b0;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1 check("reset_async", act_out(), mk(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 3'b111, 2'b11, '0));
    @(posedge clk);
    #1 check("reset_hold", act_out(), mk(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 3'b111, 2'b11, '0));
    #3 rst_n = 1'b1;
    m_a = '0;
    m_s = '0;
    #1 check("reset_ready", act_out(), idle_exp());
    run_cmd(OP_PB, '0, 2, -1, 1'b0);
    check_int("pumpb_busy_cycles", nbusy, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
